// File: rtl/tlc_pkg.sv
// Shared definitions for the adaptive multi-approach traffic light controller.
package tlc_pkg;

    localparam logic [1:0] LampRed    = 2'b00;
    localparam logic [1:0] LampYellow = 2'b01;
    localparam logic [1:0] LampGreen  = 2'b10;

    typedef enum logic [1:0] {
        PhAllRed = 2'b00,
        PhGreen  = 2'b01,
        PhYellow = 2'b10
    } phase_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] req);
        logic [2:0] res;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) res = 3'(i);
        end
        return res;
    endfunction

    // Round-robin search starting after cur, wrapping modulo n; cur itself is tried last.
    // With no request set this is plain rotation to (cur + 1) mod n.
    function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] cur,
                                           input int unsigned n);
        int unsigned c;
        int unsigned idx;
        logic        found;
        logic [2:0]  res;
        c     = 32'(cur);
        res   = 3'((c + 1) % n);
        found = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            if (i <= n && !found) begin
                idx = (c + i) % n;
                if (req[idx[2:0]]) begin
                    res   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase down-counter: load on phase entry, hold while frozen, saturate at zero.
module tlc_phase_timer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             freeze,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    // Count register; load wins over freeze.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else if (load) begin
            cnt_q <= load_val;
        end else if (!freeze && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/adaptive_tlc_multi.sv
// Round-robin adaptive traffic light controller for N_DIR approaches with
// queue-based green extension, optional empty-approach skipping and emergency preemption.
module adaptive_tlc_multi
    import tlc_pkg::*;
#(
    parameter int unsigned N_DIR       = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_BASE      = 8,
    parameter int unsigned T_EXT_SHORT = 4,
    parameter int unsigned T_EXT_LONG  = 8,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 2,
    parameter int unsigned SKIP_EMPTY  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DIR-1:0]   s1,
    input  logic [N_DIR-1:0]   s5,
    input  logic [N_DIR-1:0]   emg,
    output logic [2*N_DIR-1:0] lights,
    output logic [1:0]         phase,
    output logic [2:0]         green_dir,
    output logic               preempt_active
);

    localparam logic [CNT_W-1:0] LdBase   = CNT_W'(T_BASE - 1);
    localparam logic [CNT_W-1:0] LdShort  = CNT_W'(T_EXT_SHORT - 1);
    localparam logic [CNT_W-1:0] LdLong   = CNT_W'(T_EXT_LONG - 1);
    localparam logic [CNT_W-1:0] LdYellow = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LdAllRed = CNT_W'(T_ALLRED - 1);

    // Widen to 8 so the 3-bit direction index always fits.
    logic [7:0] s1_w, s5_w, emg_w;
    assign s1_w  = 8'(s1);
    assign s5_w  = 8'(s5);
    assign emg_w = 8'(emg);

    phase_e             phase_q, phase_d;
    logic [2:0]         dir_q, dir_d;
    logic [2:0]         pdir_q, pdir_d;   // latched preemption target
    logic               ext_q, ext_d;     // extension already granted this green
    logic               pre_q, pre_d;
    logic [2*N_DIR-1:0] lights_q, lights_d;
    logic [2:0]         win, sel;
    logic               tmr_load, tmr_freeze, tmr_done;
    logic [CNT_W-1:0]   tmr_val;

    tlc_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (T_ALLRED - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .freeze   (tmr_freeze),
        .done     (tmr_done)
    );

    // Pick the approach served after the current all-red clearance.
    always_comb begin
        win = lowest_set(emg_w);
        if (emg_w != '0) begin
            sel = win;
        end else if (pre_q) begin
            sel = pdir_q;
        end else if (SKIP_EMPTY != 0 && (s1_w | s5_w) != '0) begin
            sel = rr_next(s1_w | s5_w, dir_q, N_DIR);
        end else begin
            sel = rr_next(8'h00, dir_q, N_DIR);
        end
    end

    // Phase sequencing, timer control and preemption bookkeeping.
    always_comb begin
        phase_d    = phase_q;
        dir_d      = dir_q;
        pdir_d     = pdir_q;
        ext_d      = ext_q;
        pre_d      = pre_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_freeze = 1'b0;
        case (phase_q)
            PhGreen: begin
                if (emg_w != '0) begin
                    pre_d = 1'b1;
                    if (win == dir_q) begin
                        tmr_freeze = 1'b1;
                    end else begin
                        // Another approach wins: cut green short, no minimum green.
                        phase_d  = PhYellow;
                        pdir_d   = win;
                        tmr_load = 1'b1;
                        tmr_val  = LdYellow;
                    end
                end else begin
                    pre_d = 1'b0;
                    if (tmr_done) begin
                        if (!ext_q && s5_w[dir_q] && T_EXT_LONG != 0) begin
                            ext_d    = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = LdLong;
                        end else if (!ext_q && s1_w[dir_q] && T_EXT_SHORT != 0) begin
                            ext_d    = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = LdShort;
                        end else begin
                            phase_d  = PhYellow;
                            tmr_load = 1'b1;
                            tmr_val  = LdYellow;
                        end
                    end
                end
            end
            PhYellow: begin
                if (tmr_done) begin
                    phase_d  = PhAllRed;
                    tmr_load = 1'b1;
                    tmr_val  = LdAllRed;
                end
            end
            default: begin
                if (tmr_done) begin
                    phase_d  = PhGreen;
                    dir_d    = sel;
                    ext_d    = 1'b0;
                    // Stays set only if the granted approach is still requesting.
                    pre_d    = (emg_w != '0);
                    tmr_load = 1'b1;
                    tmr_val  = LdBase;
                end
            end
        endcase
    end

    // Lamp pattern for the upcoming state, so lights are registered alongside phase.
    always_comb begin
        lights_d = '0;
        for (int k = 0; k < int'(N_DIR); k++) begin
            if (dir_d == 3'(k)) begin
                if (phase_d == PhGreen) begin
                    lights_d[2*k +: 2] = LampGreen;
                end else if (phase_d == PhYellow) begin
                    lights_d[2*k +: 2] = LampYellow;
                end
            end
        end
    end

    // State registers; reset drives all lamps red without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= PhAllRed;
            dir_q    <= 3'(N_DIR - 1);
            pdir_q   <= '0;
            ext_q    <= 1'b0;
            pre_q    <= 1'b0;
            lights_q <= '0;
        end else begin
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            pdir_q   <= pdir_d;
            ext_q    <= ext_d;
            pre_q    <= pre_d;
            lights_q <= lights_d;
        end
    end

    assign lights         = lights_q;
    assign phase          = phase_q;
    assign green_dir      = dir_q;
    assign preempt_active = pre_q;

endmodule

// File: tb/tb_adaptive_tlc_multi.sv
// Directed bench for adaptive_tlc_multi with default parameters.
module tb_adaptive_tlc_multi;

    localparam logic [1:0] PA = 2'b00;
    localparam logic [1:0] PG = 2'b01;
    localparam logic [1:0] PY = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] s1, s5, emg;
    logic [7:0] lights;
    logic [1:0] phase;
    logic [2:0] green_dir;
    logic       preempt_active;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adaptive_tlc_multi #(
        .N_DIR       (4),
        .CNT_W       (8),
        .T_BASE      (8),
        .T_EXT_SHORT (4),
        .T_EXT_LONG  (8),
        .T_YELLOW    (3),
        .T_ALLRED    (2),
        .SKIP_EMPTY  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s1             (s1),
        .s5             (s5),
        .emg            (emg),
        .lights         (lights),
        .phase          (phase),
        .green_dir      (green_dir),
        .preempt_active (preempt_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_lights(input logic [1:0] ph, input int d);
        logic [7:0] l;
        l = 8'h00;
        if (ph == PG) l[2*d +: 2] = 2'b10;
        else if (ph == PY) l[2*d +: 2] = 2'b01;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the current window, then measures how many cycles the phase persists.
    task automatic run_phase(input string tag, input logic [1:0] ph, input int d,
                             input int len);
        int n;
        chk({tag, ".phase"}, 32'(phase), 32'(ph));
        chk({tag, ".dir"}, 32'(green_dir), 32'(d));
        chk({tag, ".lights"}, 32'(lights), 32'(exp_lights(ph, d)));
        n = 0;
        do begin
            n++;
            tick();
        end while (phase === ph && n < 200);
        chk({tag, ".len"}, 32'(n), 32'(len));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        s1  = 4'h0;
        s5  = 4'h0;
        emg = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".rst_lights"}, 32'(lights), 32'h0);
        chk({tag, ".rst_phase"}, 32'(phase), 32'(PA));
        chk({tag, ".rst_dir"}, 32'(green_dir), 32'd3);
        chk({tag, ".rst_pre"}, 32'(preempt_active), 32'd0);
        #2 rst = 1'b1;
        #1;
    endtask

    initial begin
        // 1: plain rotation at base green
        do_reset("t1");
        run_phase("t1.a0", PA, 3, 2);
        run_phase("t1.g0", PG, 0, 8);
        run_phase("t1.y0", PY, 0, 3);
        run_phase("t1.a1", PA, 0, 2);
        run_phase("t1.g1", PG, 1, 8);
        run_phase("t1.y1", PY, 1, 3);
        run_phase("t1.a2", PA, 1, 2);
        run_phase("t1.g2", PG, 2, 8);
        run_phase("t1.y2", PY, 2, 3);
        run_phase("t1.a3", PA, 2, 2);
        run_phase("t1.g3", PG, 3, 8);
        run_phase("t1.y3", PY, 3, 3);
        run_phase("t1.a4", PA, 3, 2);
        run_phase("t1.g0b", PG, 0, 8);

        // 2: queue extensions
        do_reset("t2a");
        run_phase("t2a.a", PA, 3, 2);
        s1 = 4'b0001;
        run_phase("t2a.g0", PG, 0, 12);
        s1 = 4'h0;
        run_phase("t2a.y0", PY, 0, 3);
        run_phase("t2a.a1", PA, 0, 2);
        run_phase("t2a.g1", PG, 1, 8);

        do_reset("t2b");
        run_phase("t2b.a", PA, 3, 2);
        s1 = 4'b0001;
        s5 = 4'b0001;
        run_phase("t2b.g0", PG, 0, 16);
        s1 = 4'h0;
        s5 = 4'h0;

        // s5 rising during the short extension must not lengthen it
        do_reset("t2c");
        run_phase("t2c.a", PA, 3, 2);
        s1 = 4'b0001;
        repeat (8) tick();
        s5 = 4'b0001;
        run_phase("t2c.gext", PG, 0, 4);
        s1 = 4'h0;
        s5 = 4'h0;

        // 3: skip empty approaches
        do_reset("t3");
        run_phase("t3.a", PA, 3, 2);
        s1 = 4'b1000;
        run_phase("t3.g0", PG, 0, 8);
        run_phase("t3.y0", PY, 0, 3);
        run_phase("t3.a0", PA, 0, 2);
        run_phase("t3.g3", PG, 3, 12);
        s1 = 4'h0;
        run_phase("t3.y3", PY, 3, 3);
        run_phase("t3.a3", PA, 3, 2);
        run_phase("t3.g0b", PG, 0, 8);

        // 4a: one-cycle emergency pulse truncates dir0 green
        do_reset("t4a");
        run_phase("t4a.a", PA, 3, 2);
        repeat (2) tick();
        emg = 4'b0100;
        tick();
        emg = 4'h0;
        chk("t4a.trunc_pre", 32'(preempt_active), 32'd1);
        run_phase("t4a.y0", PY, 0, 3);
        chk("t4a.ar_pre", 32'(preempt_active), 32'd1);
        run_phase("t4a.a0", PA, 0, 2);
        chk("t4a.g2_pre", 32'(preempt_active), 32'd0);
        run_phase("t4a.g2", PG, 2, 8);

        // 4b: emg[2] held for 20 cycles freezes dir2 green
        do_reset("t4b");
        run_phase("t4b.a", PA, 3, 2);
        repeat (2) tick();
        emg = 4'b0100;
        tick();
        run_phase("t4b.y0", PY, 0, 3);
        run_phase("t4b.a0", PA, 0, 2);
        chk("t4b.g2_pre", 32'(preempt_active), 32'd1);
        repeat (14) tick();
        emg = 4'h0;
        run_phase("t4b.g2", PG, 2, 8);
        chk("t4b.end_pre", 32'(preempt_active), 32'd0);

        // 5: two simultaneous requests, lowest index first
        do_reset("t5");
        run_phase("t5.a", PA, 3, 2);
        tick();
        emg = 4'b1010;
        tick();
        run_phase("t5.y0", PY, 0, 3);
        run_phase("t5.a0", PA, 0, 2);
        chk("t5.g1_pre", 32'(preempt_active), 32'd1);
        repeat (3) tick();
        chk("t5.g1_hold", 32'(green_dir), 32'd1);
        chk("t5.g1_hold_ph", 32'(phase), 32'(PG));
        emg = 4'b1000;
        tick();
        run_phase("t5.y1", PY, 1, 3);
        run_phase("t5.a1", PA, 1, 2);
        chk("t5.g3_pre", 32'(preempt_active), 32'd1);
        emg = 4'h0;
        run_phase("t5.g3", PG, 3, 8);
        chk("t5.end_pre", 32'(preempt_active), 32'd0);

        // 6: asynchronous reset in the middle of yellow
        do_reset("t6");
        run_phase("t6.a", PA, 3, 2);
        run_phase("t6.g0", PG, 0, 8);
        tick();
        chk("t6.mid_y", 32'(phase), 32'(PY));
        #2 rst = 1'b0;
        #1;
        chk("t6.async_lights", 32'(lights), 32'h0);
        chk("t6.async_phase", 32'(phase), 32'(PA));
        chk("t6.async_dir", 32'(green_dir), 32'd3);
        #2 rst = 1'b1;
        #1;
        run_phase("t6.a0", PA, 3, 2);
        run_phase("t6.g0b", PG, 0, 8);
        run_phase("t6.y0", PY, 0, 3);
        run_phase("t6.a1", PA, 0, 2);
        run_phase("t6.g1", PG, 1, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adaptive_tlc_multi.md
Name: adaptive_tlc_multi

Overview:
Parametrised successor to the four-approach adaptive traffic light controller. Serves N_DIR approaches in round-robin order. Each approach has a near queue sensor (s1) and a far/long-queue sensor (s5), and green time is extended according to queue depth. New behaviour: optional skipping of approaches with no demand, and per-approach emergency preemption. Sits between the sensor front-end and the lamp drivers.

Parameters:
N_DIR, 4, number of approaches (2..8)
CNT_W, 8, phase timer width
T_BASE, 8, base green cycles (>=1)
T_EXT_SHORT, 4, extra green cycles when only s1 is set
T_EXT_LONG, 8, extra green cycles when s5 is set
T_YELLOW, 3, yellow cycles (>=1)
T_ALLRED, 2, all-red clearance cycles (>=1)
SKIP_EMPTY, 1, 1 = skip approaches with no demand; 0 = strict rotation

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
s1  in  N_DIR  near queue sensor per approach
s5  in  N_DIR  far queue sensor per approach (long queue)
emg  in  N_DIR  emergency preempt request per approach, level
lights  out  2*N_DIR  lamp code per approach; approach k occupies bits [2k+1:2k]
phase  out  2  current phase code
green_dir  out  3  index of the approach currently owning the phase
preempt_active  out  1  high while an emergency sequence is in progress

Behaviour:
- Lamp codes: RED=2'b00, YELLOW=2'b01, GREEN=2'b10. Phase codes: ALLRED=2'b00, GREEN=2'b01, YELLOW=2'b10.
- All outputs are registered. Only approach green_dir is non-RED, and only during the GREEN or YELLOW phase.
- Reset (rst=0, asynchronous):
  - all lights RED, phase=ALLRED, green_dir=N_DIR-1, preempt_active=0.
  - timer loaded with T_ALLRED-1.
  - Asserting reset mid-phase forces all lights RED immediately, without waiting for a clock edge.
- Timer: loaded with D-1 on phase entry and decremented each cycle. The phase ends when the timer reaches 0, so a phase of duration D lasts exactly D cycles.
- GREEN:
  - Lasts T_BASE cycles. On the last base cycle, s5/s1 of green_dir are sampled once.
  - If s5 is set, green is extended by T_EXT_LONG; otherwise, if s1 is set, by T_EXT_SHORT; otherwise the next state is YELLOW.
  - The extension is never re-sampled.
- YELLOW: lasts T_YELLOW cycles, then ALLRED.
- ALLRED: lasts T_ALLRED cycles, then GREEN for next_dir, which is chosen as follows:
  - If any emg bit is set: the lowest-index approach with emg set.
  - Else if SKIP_EMPTY=1 and any approach has s1|s5 set: the first such approach searching green_dir+1, green_dir+2, ... with wrap-around. The current approach is considered last.
  - Else: (green_dir+1) mod N_DIR.
- Emergency preemption:
  - emg[k]=1 during GREEN of a different approach: the next cycle enters YELLOW, truncating green (minimum green is not honoured). preempt_active=1.
  - emg[k]=1 during YELLOW or ALLRED: the phase completes normally, and next_dir selection grants k.
  - emg[k]=1 while k is green: the timer freezes and green holds for as long as emg[k]=1. Normal countdown resumes when emg[k] drops.
  - Multiple emg bits set: the lowest index wins. Other pending requests are served in later cycles.
  - preempt_active clears on the first cycle of GREEN for the preempting approach after emg drops.
- No demand anywhere and no emg: strict rotation at base green only.
- Sensor inputs are synchronous to clk; the block does no metastability handling.

Decomposition:
- Package tlc_pkg: lamp codes, phase codes, and a next_dir search function (round-robin priority with wrap).
- Sub-module tlc_phase_timer: CNT_W down-counter with load, freeze and done outputs. Instantiated once.

Test Plan:
1. Reset, then no sensors or emg. Required sequence, repeating:
   - phase ALLRED for 2 cycles;
   - dir0 GREEN for 8 cycles;
   - YELLOW for 3 cycles;
   - ALLRED for 2 cycles;
   - dir1 GREEN; rotation continues 0→1→2→3→0.
2. s1[0]=1 held during dir0 green → dir0 GREEN lasts 12 cycles. With s5[0]=1 as well → 16 cycles. Sensor set only after the sampling cycle → 8 cycles.
3. SKIP_EMPTY=1, only s1[3]=1 while dir0 is green → after ALLRED, green_dir=3; dirs 1 and 2 are never lit.
4. emg[2] pulsed on the 3rd green cycle of dir0 → next cycle dir0 YELLOW, preempt_active=1; 3+2 cycles later, dir2 GREEN. Hold emg[2] 20 cycles → dir2 green persists for the whole hold, then counts down its remaining time.
5. emg=4'b1010 during dir0 green → dir1 is granted first, then dir3.
6. Reset asserted mid-YELLOW, asynchronously between clock edges → lights become all RED immediately. After release, the sequence matches scenario 1 starting from dir0.
